// File: rtl/fp_ci_pkg.sv
// Shared definitions for the FP custom-instruction slave and its issuer:
// opcodes, IEEE754 single-precision constants and the issuer FSM states.
package fp_ci_pkg;

    localparam logic [1:0] OP_ADD     = 2'd0;
    localparam logic [1:0] OP_SUB     = 2'd1;
    localparam logic [1:0] OP_MUL     = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [31:0] FP_QNAN    = 32'h7fffffff;
    localparam logic [30:0] FP_INF_ABS = 31'h7f800000;
    localparam logic [30:0] FP_ONE_ABS = 31'h3f800000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ci_state_t;

    function automatic logic is_legal_op(input logic [1:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/fp_ci_watchdog.sv
// Wait-cycle watchdog: cleared when an operation is issued, counts while
// enabled and flags expiry once TIMEOUT_CYCLES wait cycles have elapsed.
module fp_ci_watchdog #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign expired = (count_reg == LAST);

    // Saturate at LAST so a stalled enable never wraps back to zero.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expired) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fp_ci_issuer.sv
// Initiator for the multi-cycle FP custom-instruction slave: takes commands on
// a valid/ready stream, pulses start once, waits for done under a watchdog.
module fp_ci_issuer
    import fp_ci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 16,
    parameter int ADD_OPCODE     = 0,
    parameter int SUB_OPCODE     = 1,
    parameter int MUL_OPCODE     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_timeout,
    output logic             rsp_error,
    output logic [31:0]      ci_dataa,
    output logic [31:0]      ci_datab,
    output logic [1:0]       ci_n,
    output logic             ci_start,
    output logic             ci_clk_en,
    output logic             ci_reset,
    input  logic             ci_done,
    input  logic [31:0]      ci_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] N_ADD = 2'(ADD_OPCODE);
    localparam logic [1:0] N_SUB = 2'(SUB_OPCODE);
    localparam logic [1:0] N_MUL = 2'(MUL_OPCODE);

    ci_state_t        state_reg, state_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic [1:0]       op_reg, op_next;
    logic [31:0]      result_reg, result_next;
    logic             timeout_reg, timeout_next;
    logic             error_reg, error_next;
    logic [CNT_W-1:0] op_count_reg, op_count_next;
    logic             wd_expired;

    fp_ci_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .srst    (reset),
        .clear   (state_reg == ST_ISSUE),
        .enable  ((state_reg == ST_WAIT) && !ci_done),
        .expired (wd_expired)
    );

    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        op_next       = op_reg;
        result_next   = result_reg;
        timeout_next  = timeout_reg;
        error_next    = error_reg;
        op_count_next = op_count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_next  = cmd_a;
                    b_next  = cmd_b;
                    op_next = cmd_op;
                    if (!is_legal_op(cmd_op)) begin
                        result_next  = FP_QNAN;
                        error_next   = 1'b1;
                        timeout_next = 1'b0;
                        state_next   = ST_RESP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes precedence over a watchdog expiring in the same cycle
                if (ci_done) begin
                    result_next  = ci_result;
                    timeout_next = 1'b0;
                    error_next   = 1'b0;
                    state_next   = ST_RESP;
                end else if (wd_expired) begin
                    result_next  = FP_QNAN;
                    timeout_next = 1'b1;
                    error_next   = 1'b0;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_next = op_count_reg + 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            result_reg   <= '0;
            timeout_reg  <= 1'b0;
            error_reg    <= 1'b0;
            op_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            op_reg       <= op_next;
            result_reg   <= result_next;
            timeout_reg  <= timeout_next;
            error_reg    <= error_next;
            op_count_reg <= op_count_next;
        end
    end

    // Operands come straight from registers so the slave's combinational
    // special-value bypass sees stable inputs for the whole operation.
    always_comb begin
        case (op_reg)
            OP_ADD:  ci_n = N_ADD;
            OP_SUB:  ci_n = N_SUB;
            OP_MUL:  ci_n = N_MUL;
            default: ci_n = op_reg;
        endcase
    end

    assign ci_dataa    = a_reg;
    assign ci_datab    = b_reg;
    assign ci_start    = (state_reg == ST_ISSUE);
    assign ci_clk_en   = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) && !reset;
    assign ci_reset    = reset;
    assign cmd_ready   = (state_reg == ST_IDLE) && !reset;
    assign rsp_valid   = (state_reg == ST_RESP);
    assign rsp_result  = result_reg;
    assign rsp_timeout = timeout_reg;
    assign rsp_error   = error_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_fp_ci_issuer.sv
// Bench for fp_ci_issuer: behavioural multi-cycle slave with programmable
// latency, directed cases followed by randomized commands against a model.
module tb_fp_ci_issuer;
    import fp_ci_pkg::*;

    localparam int TO = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [31:0]   cmd_a = '0;
    logic [31:0]   cmd_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_result;
    logic          rsp_timeout;
    logic          rsp_error;
    logic [31:0]   ci_dataa;
    logic [31:0]   ci_datab;
    logic [1:0]    ci_n;
    logic          ci_start;
    logic          ci_clk_en;
    logic          ci_reset;
    logic          ci_done;
    logic [31:0]   ci_result;
    logic          busy;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    fp_ci_issuer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout), .rsp_error(rsp_error),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_n(ci_n),
        .ci_start(ci_start), .ci_clk_en(ci_clk_en), .ci_reset(ci_reset),
        .ci_done(ci_done), .ci_result(ci_result),
        .busy(busy), .op_count(op_count)
    );

    int total = 0;
    int bad = 0;
    int exp_count = 0;

    // Behavioural slave: result appears with done exactly L cycles after start.
    int          s_lat = 1;
    logic        s_en = 1'b1;
    logic        done_force = 1'b0;
    logic        s_active = 1'b0;
    int          s_cnt = 0;
    logic [31:0] s_res = '0;

    function automatic logic [31:0] slave_fn(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] n);
        if (n == OP_ADD && a == 32'h3f800000 && b == 32'h40000000) return 32'h40400000;
        if (n == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40c00000;
        if (n == OP_ADD && a == 32'h7f800000 && b == 32'h3f800000) return 32'h7f800000;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, n} + 32'h1234_5678;
    endfunction

    always @(posedge clk) begin
        if (ci_start) begin
            s_active <= 1'b1;
            s_cnt    <= s_lat - 1;
            s_res    <= slave_fn(ci_dataa, ci_datab, ci_n);
        end else if (s_active) begin
            if (s_cnt == 0) s_active <= 1'b0;
            else            s_cnt    <= s_cnt - 1;
        end
    end

    assign ci_done   = (s_active && s_cnt == 0 && s_en) || done_force;
    assign ci_result = s_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command and check latency, slave protocol and response fields.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic den, input int hold);
        logic [31:0] exp_res;
        logic        exp_to, exp_err;
        int          exp_lat, starts, start_k, got_k, clken;
        logic [31:0] a_seen, b_seen;
        logic [1:0]  n_seen;
        if (op == OP_ILLEGAL) begin
            exp_res = FP_QNAN; exp_to = 1'b0; exp_err = 1'b1; exp_lat = 1;
        end else if (den && lat <= TO) begin
            exp_res = slave_fn(a, b, op); exp_to = 1'b0; exp_err = 1'b0; exp_lat = lat + 2;
        end else begin
            exp_res = FP_QNAN; exp_to = 1'b1; exp_err = 1'b0; exp_lat = TO + 2;
        end
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 1);
        s_lat = lat; s_en = den;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        starts = 0; start_k = 0; got_k = 0; clken = 0;
        a_seen = '0; b_seen = '0; n_seen = '0;
        for (int i = 1; i <= TO + 40 && got_k == 0; i++) begin
            @(negedge clk);
            if (ci_clk_en) clken++;
            if (ci_start) begin
                starts++; start_k = i;
                a_seen = ci_dataa; b_seen = ci_datab; n_seen = ci_n;
            end
            if (rsp_valid) got_k = i;
        end
        check("rsp_latency", got_k, exp_lat);
        check("start_pulses", starts, (op == OP_ILLEGAL) ? 0 : 1);
        check("clk_en_cycles", clken, (op == OP_ILLEGAL) ? 0 : exp_lat - 1);
        if (op != OP_ILLEGAL) begin
            check("start_cycle", start_k, 1);
            check("start_dataa", a_seen, a);
            check("start_datab", b_seen, b);
            check("start_n", {30'd0, n_seen}, {30'd0, op});
        end
        check("resp_dataa_stable", ci_dataa, a);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
        check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
        check("resp_busy", {31'd0, busy}, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 1);
            check("hold_result", rsp_result, exp_res);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CW);
        @(negedge clk);
        check("op_count", {26'd0, op_count}, exp_count);
        check("rsp_valid_after", {31'd0, rsp_valid}, 0);
        check("cmd_ready_after", {31'd0, cmd_ready}, 1);
        $display("op=%0d a=%h b=%h L=%0d done_en=%0b lat=%0d res=%h to=%0b err=%0b cnt=%0d",
                 op, a, b, lat, den, got_k, rsp_result, rsp_timeout, rsp_error, op_count);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_ci_reset", {31'd0, ci_reset}, 1);
        check("rst_clk_en", {31'd0, ci_clk_en}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("init_cmd_ready", {31'd0, cmd_ready}, 1);
        check("init_rsp_valid", {31'd0, rsp_valid}, 0);
        check("init_result", rsp_result, 0);
        check("init_flags", {30'd0, rsp_timeout, rsp_error}, 0);
        check("init_op_count", {26'd0, op_count}, 0);
        check("init_busy", {31'd0, busy}, 0);
        check("init_ci_reset", {31'd0, ci_reset}, 0);
        check("init_dataa", ci_dataa, 0);

        run_op(OP_ADD, 32'h3f800000, 32'h40000000, 7, 1'b1, 0);
        run_op(OP_MUL, 32'h40000000, 32'h40400000, 5, 1'b1, 4);
        run_op(OP_SUB, 32'h40400000, 32'h3f800000, 3, 1'b0, 1);
        run_op(OP_ILLEGAL, 32'h11111111, 32'h22222222, 1, 1'b1, 0);
        run_op(OP_ADD, 32'h7f800000, 32'h3f800000, 1, 1'b1, 0);
        run_op(OP_SUB, 32'h12345678, 32'h9abcdef0, TO, 1'b1, 0);
        run_op(OP_MUL, 32'h0badf00d, 32'hcafef00d, TO + 1, 1'b1, 0);
        run_op(OP_ADD, 32'h01020304, 32'h05060708, TO - 1, 1'b1, 2);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            run_op(rop, $urandom, $urandom, int'($urandom_range(1, 12)),
                   ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of WAIT; the slave still raises done later.
        @(negedge clk);
        s_lat = 10; s_en = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'h3f800000; cmd_b = 32'h3f800000;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midop_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("midrst_clk_en", {31'd0, ci_clk_en}, 0);
        check("midrst_ci_reset", {31'd0, ci_reset}, 1);
        reset = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("postrst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("postrst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("postrst_op_count", {26'd0, op_count}, 0);
        check("postrst_result", rsp_result, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid || busy || ci_start) seen++;
        end
        check("late_done_ignored", seen, 0);

        while (exp_count != (1 << CW) - 1) begin
            run_op(OP_ILLEGAL, $urandom, $urandom, 1, 1'b1, 0);
        end
        check("count_all_ones", {26'd0, op_count}, (1 << CW) - 1);
        run_op(OP_ADD, 32'h40000000, 32'h40000000, 2, 1'b1, 0);
        check("count_wrap_zero", {26'd0, op_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
